// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide engine.
// Op codes, FSM states and the divide-by-zero quotient constant.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes at start,
// and sign correction of the raw accumulator at the fix step.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg_a,
  output logic               neg_b,
  input  logic               is_div,
  input  logic               fix_a,
  input  logic               fix_b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    // Most-negative value negates to itself, read as unsigned.
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;

    prod = (fix_a ^ fix_b) ? -acc : acc;
    quo  = (fix_a ^ fix_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = fix_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = is_div ? quo : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 sequential mult/multu/div/divu engine owning HI/LO.
// start/busy/done handshake; fixed 33-edge latency per op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic               div0_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               ge;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .sgn    (op_is_signed(op)),
    .a      (op_a),
    .b      (op_b),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .is_div (op_is_div(op_q)),
    .fix_a  (sa_q),
    .fix_b  (sb_q),
    .acc    (acc),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // opnd_q holds the multiplicand for mult, the divisor for div.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    if (op_is_div(op_q))
      acc_nxt = {ge ? rem_diff : rem_sh[WIDTH-1:0],
                 acc[WIDTH-2:0], ge};
    else
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      acc     <= '0;
    end else begin
      done <= (state == S_FIX);
      unique case (state)
        S_IDLE: begin
          if (mthi) hi <= op_a;
          if (mtlo) lo <= op_a;
          if (start) begin
            op_q    <= op;
            sa_q    <= neg_a;
            sb_q    <= neg_b;
            cnt     <= '0;
            opnd_q  <= op_is_div(op) ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}},
                        op_is_div(op) ? mag_a : mag_b};
            a_raw_q <= op_a;
            div0_q  <= op_is_div(op) & (op_b == '0);
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (div0_q) begin
            hi <= a_raw_q;
            lo <= DIV0_LO;
          end else begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
